mips_mc_controller: RTL and testbench

- Full multicycle MIPS control unit. A Moore FSM drives every datapath mux select and write enable.
- Next generation of the team's skeleton controller:
  - decodes R-type funct, LW/SW, BEQ/BNE, ADDI/ANDI/ORI/SLTI and J;
  - adds an optional memory-ready handshake;
  - adds an illegal-instruction trap.
- Sits between the instruction register (Op/Funct) and the multicycle datapath (PC, IR, regfile, ALU, unified memory).

---
 rtl/mips_mc_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects and write enables,
// with an optional memory-ready handshake and an illegal-instruction trap.
module mips_mc_controller #(
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       ImmZext,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StFetch   = 4'b0000,
    StDecode  = 4'b0001,
    StMemAdr  = 4'b0010,
    StMemRd   = 4'b0011,
    StMemWb   = 4'b0100,
    StMemWr   = 4'b0101,
    StRtypeEx = 4'b0110,
    StRtypeWb = 4'b0111,
    StBex     = 4'b1000,
    StItypeEx = 4'b1001,
    StItypeWb = 4'b1010,
    StJex     = 4'b1011,
    StTrap    = 4'b1100
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e state_q, state_d;

  logic       mem_rdy;
  logic       funct_legal;
  logic [2:0] funct_alu;
  logic [2:0] itype_alu;

  // Without the handshake, memory is treated as always ready.
  assign mem_rdy = MEM_HANDSHAKE ? MemReady : 1'b1;

  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = AluAdd;
    case (Funct)
      FnAdd:   funct_alu = AluAdd;
      FnSub:   funct_alu = AluSub;
      FnAnd:   funct_alu = AluAnd;
      FnOr:    funct_alu = AluOr;
      FnSlt:   funct_alu = AluSlt;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    itype_alu = AluAdd;
    case (Op)
      OpAndi:  itype_alu = AluAnd;
      OpOri:   itype_alu = AluOr;
      OpSlti:  itype_alu = AluSlt;
      default: itype_alu = AluAdd;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = StFetch;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCEn       = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = AluAdd;
    ImmZext    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    Illegal    = 1'b0;

    case (state_q)
      StFetch: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_rdy;
        PCEn    = mem_rdy;
        state_d = mem_rdy ? StDecode : StFetch;
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        case (Op)
          OpLw, OpSw:                    state_d = StMemAdr;
          OpBeq, OpBne:                  state_d = StBex;
          OpAddi, OpAndi, OpOri, OpSlti: state_d = StItypeEx;
          OpJ:                           state_d = StJex;
          OpRtype: begin
            if (funct_legal) begin
              state_d = StRtypeEx;
            end else begin
              state_d = TRAP_ON_ILLEGAL ? StTrap : StFetch;
            end
          end
          default: state_d = TRAP_ON_ILLEGAL ? StTrap : StFetch;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        IorD    = 1'b1;
        state_d = mem_rdy ? StMemWb : StMemRd;
      end
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StMemWr: begin
        // Strobe stays up until the memory accepts the write.
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = mem_rdy ? StFetch : StMemWr;
      end
      StRtypeEx: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
        state_d    = StRtypeWb;
      end
      StRtypeWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBex: begin
        ALUSrcA    = 1'b1;
        ALUControl = AluSub;
        PCSrc      = 2'b01;
        PCEn       = ((Op == OpBeq) & Zero) | ((Op == OpBne) & ~Zero);
      end
      StItypeEx: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = itype_alu;
        ImmZext    = (Op == OpAndi) | (Op == OpOri);
        state_d    = StItypeWb;
      end
      StItypeWb: begin
        RegWrite = 1'b1;
      end
      StJex: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      StTrap: begin
        Illegal = 1'b1;
        state_d = StTrap;
      end
      default: state_d = StFetch;
    endcase

    // Reset masks every enable and select so an aborted instruction writes nothing.
    if (Reset) begin
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCEn       = 1'b0;
      PCSrc      = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = AluAdd;
      ImmZext    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      Illegal    = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: table of per-cycle vectors plus hand-written trap,
// no-trap and no-handshake sequences on a second instance.
module tb_mips_mc_controller;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       iord, mem_write, ir_write, pc_en, alu_src_a, imm_zext, reg_dst, mem_to_reg;
  logic       reg_write, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctl;
  logic [3:0] state;

  logic       b_iord, b_mem_write, b_ir_write, b_pc_en, b_alu_src_a, b_imm_zext, b_reg_dst;
  logic       b_mem_to_reg, b_reg_write, b_illegal;
  logic [1:0] b_pc_src, b_alu_src_b;
  logic [2:0] b_alu_ctl;
  logic [3:0] b_state;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mips_mc_controller #(
    .MEM_HANDSHAKE  (1'b1),
    .TRAP_ON_ILLEGAL(1'b1)
  ) u_dut (
    .CLK       (clk),
    .Reset     (rst),
    .Op        (op),
    .Funct     (funct),
    .Zero      (zero),
    .MemReady  (mem_ready),
    .IorD      (iord),
    .MemWrite  (mem_write),
    .IRWrite   (ir_write),
    .PCEn      (pc_en),
    .PCSrc     (pc_src),
    .ALUSrcA   (alu_src_a),
    .ALUSrcB   (alu_src_b),
    .ALUControl(alu_ctl),
    .ImmZext   (imm_zext),
    .RegDst    (reg_dst),
    .MemtoReg  (mem_to_reg),
    .RegWrite  (reg_write),
    .Illegal   (illegal),
    .State     (state)
  );

  mips_mc_controller #(
    .MEM_HANDSHAKE  (1'b0),
    .TRAP_ON_ILLEGAL(1'b0)
  ) u_dut_b (
    .CLK       (clk),
    .Reset     (rst),
    .Op        (op),
    .Funct     (funct),
    .Zero      (zero),
    .MemReady  (mem_ready),
    .IorD      (b_iord),
    .MemWrite  (b_mem_write),
    .IRWrite   (b_ir_write),
    .PCEn      (b_pc_en),
    .PCSrc     (b_pc_src),
    .ALUSrcA   (b_alu_src_a),
    .ALUSrcB   (b_alu_src_b),
    .ALUControl(b_alu_ctl),
    .ImmZext   (b_imm_zext),
    .RegDst    (b_reg_dst),
    .MemtoReg  (b_mem_to_reg),
    .RegWrite  (b_reg_write),
    .Illegal   (b_illegal),
    .State     (b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed order: iord mw irw pcen pcsrc[2] asa asb[2] alu[3] zx rd m2r rw ill (17 bits)
  function automatic logic [16:0] ex(input logic io, input logic mw, input logic irw,
                                     input logic pce, input logic [1:0] ps, input logic asa,
                                     input logic [1:0] asb, input logic [2:0] alu,
                                     input logic zx, input logic rd, input logic m2r,
                                     input logic rw, input logic ill);
    return {io, mw, irw, pce, ps, asa, asb, alu, zx, rd, m2r, rw, ill};
  endfunction

  function automatic logic [16:0] act_a();
    return {iord, mem_write, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_ctl,
            imm_zext, reg_dst, mem_to_reg, reg_write, illegal};
  endfunction

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        rdy;
    logic        chk_state;
    logic [3:0]  exp_state;
    logic [16:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic add(input string name, input logic r, input logic [5:0] o,
                     input logic [5:0] f, input logic z, input logic rdy, input logic cs,
                     input logic [3:0] st, input logic [16:0] eo);
    vec_t v;
    v.name = name; v.rst = r; v.op = o; v.funct = f; v.zero = z; v.rdy = rdy;
    v.chk_state = cs; v.exp_state = st; v.exp_out = eo;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [16:0] o_rst, o_fetch, o_fstall, o_dec;

  initial begin
    o_rst    = ex(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0);
    o_fetch  = ex(0, 0, 1, 1, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0, 0);
    o_fstall = ex(0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0, 0);
    o_dec    = ex(0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0, 0, 0);

    add("rst0", 1, 6'b100011, 6'd0, 0, 1, 1, 4'd0, o_rst);
    add("rst1", 1, 6'b100011, 6'd0, 0, 1, 1, 4'd0, o_rst);
    add("rst2", 1, 6'b100011, 6'd0, 0, 1, 1, 4'd0, o_rst);
    // LW, MemReady=1
    add("lw_fetch",  0, 6'b100011, 6'd0, 0, 1, 1, 4'd0, o_fetch);
    add("lw_dec",    0, 6'b100011, 6'd0, 0, 1, 1, 4'd1, o_dec);
    add("lw_memadr", 0, 6'b100011, 6'd0, 0, 1, 1, 4'd2,
        ex(0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0));
    add("lw_memrd",  0, 6'b100011, 6'd0, 0, 1, 1, 4'd3,
        ex(1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0));
    add("lw_memwb",  0, 6'b100011, 6'd0, 0, 1, 1, 4'd4,
        ex(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 1, 1, 0));
    // SW with two not-ready cycles in MEMWR, then a stalled FETCH
    add("sw_fetch",  0, 6'b101011, 6'd0, 0, 1, 1, 4'd0, o_fetch);
    add("sw_dec",    0, 6'b101011, 6'd0, 0, 1, 1, 4'd1, o_dec);
    add("sw_memadr", 0, 6'b101011, 6'd0, 0, 1, 1, 4'd2,
        ex(0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0));
    add("sw_wr0",    0, 6'b101011, 6'd0, 0, 0, 1, 4'd5,
        ex(1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0));
    add("sw_wr1",    0, 6'b101011, 6'd0, 0, 0, 1, 4'd5,
        ex(1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0));
    add("sw_wr2",    0, 6'b101011, 6'd0, 0, 1, 1, 4'd5,
        ex(1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0));
    add("fetch_stall", 0, 6'b000100, 6'd0, 1, 0, 1, 4'd0, o_fstall);
    // BEQ taken, BNE not taken, BNE taken
    add("beq_fetch", 0, 6'b000100, 6'd0, 1, 1, 1, 4'd0, o_fetch);
    add("beq_dec",   0, 6'b000100, 6'd0, 1, 1, 1, 4'd1, o_dec);
    add("beq_bex",   0, 6'b000100, 6'd0, 1, 1, 1, 4'd8,
        ex(0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 0, 0));
    add("bne1_fetch", 0, 6'b000101, 6'd0, 1, 1, 1, 4'd0, o_fetch);
    add("bne1_dec",   0, 6'b000101, 6'd0, 1, 1, 1, 4'd1, o_dec);
    add("bne1_bex",   0, 6'b000101, 6'd0, 1, 1, 1, 4'd8,
        ex(0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 0, 0));
    add("bne0_fetch", 0, 6'b000101, 6'd0, 0, 1, 1, 4'd0, o_fetch);
    add("bne0_dec",   0, 6'b000101, 6'd0, 0, 1, 1, 4'd1, o_dec);
    add("bne0_bex",   0, 6'b000101, 6'd0, 0, 1, 1, 4'd8,
        ex(0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 0, 0));
    // R-type SLT
    add("slt_fetch", 0, 6'b000000, 6'b101010, 0, 1, 1, 4'd0, o_fetch);
    add("slt_dec",   0, 6'b000000, 6'b101010, 0, 1, 1, 4'd1, o_dec);
    add("slt_ex",    0, 6'b000000, 6'b101010, 0, 1, 1, 4'd6,
        ex(0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b111, 0, 0, 0, 0, 0));
    add("slt_wb",    0, 6'b000000, 6'b101010, 0, 1, 1, 4'd7,
        ex(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 1, 0, 1, 0));
    // ORI
    add("ori_fetch", 0, 6'b001101, 6'd0, 0, 1, 1, 4'd0, o_fetch);
    add("ori_dec",   0, 6'b001101, 6'd0, 0, 1, 1, 4'd1, o_dec);
    add("ori_ex",    0, 6'b001101, 6'd0, 0, 1, 1, 4'd9,
        ex(0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b001, 1, 0, 0, 0, 0));
    add("ori_wb",    0, 6'b001101, 6'd0, 0, 1, 1, 4'd10,
        ex(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 1, 0));
    // J
    add("j_fetch", 0, 6'b000010, 6'd0, 0, 1, 1, 4'd0, o_fetch);
    add("j_dec",   0, 6'b000010, 6'd0, 0, 1, 1, 4'd1, o_dec);
    add("j_ex",    0, 6'b000010, 6'd0, 0, 1, 1, 4'd11,
        ex(0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0));
    // ADD aborted by reset in RTYPEEX
    add("abort_fetch", 0, 6'b000000, 6'b100000, 0, 1, 1, 4'd0, o_fetch);
    add("abort_dec",   0, 6'b000000, 6'b100000, 0, 1, 1, 4'd1, o_dec);
    add("abort_ex",    1, 6'b000000, 6'b100000, 0, 1, 0, 4'd0, o_rst);
    add("abort_after", 0, 6'b000000, 6'b100000, 0, 1, 1, 4'd0, o_fetch);

    rst = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
      zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      @(negedge clk);
      if (vecs[i].chk_state) chk({vecs[i].name, ".state"}, 32'(state), 32'(vecs[i].exp_state));
      chk({vecs[i].name, ".out"}, 32'(act_a()), 32'(vecs[i].exp_out));
      step();
    end

    // Illegal opcode: trap instance sticks in TRAP, other instance drops back to FETCH.
    // The second instance also ignores MemReady in FETCH.
    rst = 1'b1; mem_ready = 1'b1; op = 6'b111111; funct = 6'd0;
    step();
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("ill_a_fetch_stall_irw", 32'(ir_write), 32'd0);
    chk("ill_b_nohs_irw", 32'(b_ir_write), 32'd1);
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("ill_a_state_fetch", 32'(state), 32'd0);
    chk("ill_b_state_dec", 32'(b_state), 32'd1);
    step();
    @(negedge clk);
    chk("ill_a_state_dec", 32'(state), 32'd1);
    chk("ill_b_back_fetch", 32'(b_state), 32'd0);
    chk("ill_b_illegal", 32'(b_illegal), 32'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ill_a_trap_state", 32'(state), 32'd12);
      chk("ill_a_trap_out", 32'(act_a()),
          32'(ex(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0, 0, 0, 1)));
      chk("ill_b_illegal", 32'(b_illegal), 32'd0);
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("trap_rst_illegal", 32'(illegal), 32'd0);
    step();
    @(negedge clk);
    chk("trap_rst_state", 32'(state), 32'd0);

    // Undecoded R-type funct also traps
    rst = 1'b0; op = 6'b000000; funct = 6'b000000;
    step();
    step();
    @(negedge clk);
    chk("bad_funct_state", 32'(state), 32'd12);
    chk("bad_funct_illegal", 32'(illegal), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
